sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set SRAM word-address width (512 words).
REQ-002 Parameter BURST_MAX, default 4, SHALL set the maximum number of consecutive grants to one requester while the other waits.
REQ-003 clk_g  input  1  single clock; all logic on its rising edge.
REQ-004 rst_g  input  1  asynchronous active-high reset.
REQ-005 mN_valid  input  1  request from requester N (N=0 core, N=1 loader).
REQ-006 mN_ready  output  1  request accepted this cycle.
REQ-007 mN_we  input  1  1=write, 0=read.
REQ-008 mN_wmask  input  4  byte write enables.
REQ-009 mN_addr  input  ADDR_W  word address.
REQ-010 mN_wdata  input  32  write data.
REQ-011 mN_rvalid  output  1  read data valid for requester N.
REQ-012 mN_rdata  output  32  read data.
REQ-013 sram_csb0, sram_web0  output  1 each  active-low chip select / write enable to SRAM port 0.
REQ-014 sram_wmask0  output  4; sram_addr0  output  ADDR_W; sram_din0  output  32; sram_dout0  input  32.

Function
REQ-015 Handshake: transfer when mN_valid && mN_ready; requester SHALL hold all request fields stable while valid && !ready.
REQ-016 mN_ready SHALL be combinational from mN_valid and arbiter state; at most one ready high per cycle.
REQ-017 Owner FSM states IDLE, OWN0, OWN1; burst counter 0..BURST_MAX.
REQ-018 Only one requester valid: it is granted; FSM moves to its OWN state; counter resets to 1 if owner changes, else increments (saturating).
REQ-019 Both valid in IDLE: m0 granted.
REQ-020 Both valid in OWNn: owner granted while counter < BURST_MAX; else other requester granted, counter=1.
REQ-021 No valid: FSM to IDLE, counter=0.
REQ-022 Accepted request SHALL be registered onto sram_* in the next cycle (csb0=0, web0=!we, wmask/addr/din copied); otherwise csb0=1, web0=1, other sram outputs hold.
REQ-023 Read latency: mN_rvalid SHALL pulse exactly 2 cycles after the accepting edge, for the accepting requester only; mN_rdata = sram_dout0 combinationally, value undefined when rvalid=0.
REQ-024 Writes produce no rvalid.
REQ-025 Back-to-back accepts every cycle SHALL be sustained; read-after-write to the same address accepted in the next cycle SHALL return the new data.
REQ-026 Pipeline tag (2-stage requester id + read flag) SHALL keep response order equal to accept order.

Reset
REQ-027 On rst_g: sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, mN_rvalid=0, FSM=IDLE, counter=0.
REQ-028 Reads in flight at reset SHALL be discarded; no rvalid after release.
REQ-029 First accept possible in the first cycle after rst_g deasserts.

Configuration
REQ-030 Macro SRAM_ARB_FIXED_PRIO_EN defined: m0 always wins when both valid, BURST_MAX ignored, counter not implemented.
REQ-031 Macro undefined: burst-limited arbitration per REQ-018..REQ-021.

Structure
REQ-032 Shared package c0_sram_pkg SHALL hold owner-state enum, requester-id constants, SRAM data width (32) and mask width (4).
REQ-033 No sub-modules; arbiter, SRAM command register and response tag pipeline in one module.

Verification
REQ-034 m1 writes 0xDEADBEEF, mask 0xF, addr 0x005; m0 reads 0x005 next cycle -> m0_rvalid 2 cycles after its accept, m0_rdata=0xDEADBEEF, m1_rvalid never high.
REQ-035 Both valid continuously from IDLE, BURST_MAX=4 -> grant pattern 0,0,0,0,1,1,1,1,0...; with SRAM_ARB_FIXED_PRIO_EN -> m0 every cycle, m1_ready never high.
REQ-036 Write 0x11223344 mask 0xF, then write 0xAABBCCDD mask 0x3 to addr 0x1FF, read it -> rdata=0x1122CCDD.
REQ-037 m0 read accepted, rst_g asserted next cycle -> m0_rvalid stays 0; sram_csb0=1 during and after reset until a new accept.
REQ-038 m0 holds valid with m1 owner at counter<BURST_MAX -> m0_ready=0, m0 fields held; m0 granted when counter hits BURST_MAX or m1 drops valid.

Source files
------------

// File: rtl/c0_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : c0_sram_pkg
// Brief    : Shared types and constants for the two-requester SRAM port
//            arbiter (owner state, requester ids, SRAM data/mask widths).
// Revision : 1.0 - initial release
// ============================================================================
package c0_sram_pkg;

    localparam int c_SRAM_DATA_W = 32;
    localparam int c_SRAM_MASK_W = 4;

    localparam logic c_REQ_ID_CORE   = 1'b0;
    localparam logic c_REQ_ID_LOADER = 1'b1;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } owner_e;

    // rd marks a read whose data must be returned; id selects the requester
    typedef struct packed {
        logic rd;
        logic id;
    } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Arbitrates a core (m0) and a loader (m1) onto one SRAM port with
//            burst-limited ownership, registered SRAM command and a 2-stage
//            response tag. Define SRAM_ARB_FIXED_PRIO_EN for fixed m0 priority.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import c0_sram_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk_g,
    input  logic                     rst_g,

    input  logic                     m0_valid,
    output logic                     m0_ready,
    input  logic                     m0_we,
    input  logic [c_SRAM_MASK_W-1:0] m0_wmask,
    input  logic [ADDR_W-1:0]        m0_addr,
    input  logic [c_SRAM_DATA_W-1:0] m0_wdata,
    output logic                     m0_rvalid,
    output logic [c_SRAM_DATA_W-1:0] m0_rdata,

    input  logic                     m1_valid,
    output logic                     m1_ready,
    input  logic                     m1_we,
    input  logic [c_SRAM_MASK_W-1:0] m1_wmask,
    input  logic [ADDR_W-1:0]        m1_addr,
    input  logic [c_SRAM_DATA_W-1:0] m1_wdata,
    output logic                     m1_rvalid,
    output logic [c_SRAM_DATA_W-1:0] m1_rdata,

    output logic                     sram_csb0,
    output logic                     sram_web0,
    output logic [c_SRAM_MASK_W-1:0] sram_wmask0,
    output logic [ADDR_W-1:0]        sram_addr0,
    output logic [c_SRAM_DATA_W-1:0] sram_din0,
    input  logic [c_SRAM_DATA_W-1:0] sram_dout0
);

    logic                     w_grant0;
    logic                     w_grant1;
    logic                     w_accept;
    logic                     w_sel_we;
    logic [c_SRAM_MASK_W-1:0] w_sel_wmask;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic [c_SRAM_DATA_W-1:0] w_sel_wdata;

    logic                     r_csb;
    logic                     r_web;
    logic [c_SRAM_MASK_W-1:0] r_wmask;
    logic [ADDR_W-1:0]        r_addr;
    logic [c_SRAM_DATA_W-1:0] r_din;
    rsp_tag_t                 r_tag1;
    rsp_tag_t                 r_tag2;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Fixed priority: the core always wins, so no ownership history is kept.
    always_comb begin
        w_grant0 = m0_valid;
        w_grant1 = m1_valid && !m0_valid;
    end
`else
    localparam int         c_CNT_W     = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [1:0] c_ST_IDLE   = OWNER_IDLE;
    localparam logic [1:0] c_ST_OWN0   = OWNER_M0;
    localparam logic [1:0] c_ST_OWN1   = OWNER_M1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BURST_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_burst_done;

    assign w_burst_done = (r_cnt >= c_CNT_MAX);

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (m0_valid && !m1_valid) begin
            w_grant0 = 1'b1;
        end else if (m1_valid && !m0_valid) begin
            w_grant1 = 1'b1;
        end else if (m0_valid && m1_valid) begin
            // The current owner keeps the port until its burst budget is spent.
            case (r_state)
                c_ST_OWN0: begin
                    w_grant0 = !w_burst_done;
                    w_grant1 = w_burst_done;
                end
                c_ST_OWN1: begin
                    w_grant1 = !w_burst_done;
                    w_grant0 = w_burst_done;
                end
                default: begin
                    w_grant0 = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else if (w_grant0) begin
            if (r_state != c_ST_OWN0) begin
                r_state <= c_ST_OWN0;
                r_cnt   <= c_CNT_ONE;
            end else if (!w_burst_done) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end else if (w_grant1) begin
            if (r_state != c_ST_OWN1) begin
                r_state <= c_ST_OWN1;
                r_cnt   <= c_CNT_ONE;
            end else if (!w_burst_done) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end else begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end
    end
`endif

    assign m0_ready = w_grant0;
    assign m1_ready = w_grant1;
    assign w_accept = w_grant0 || w_grant1;

    always_comb begin
        w_sel_we    = m0_we;
        w_sel_wmask = m0_wmask;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        if (w_grant1) begin
            w_sel_we    = m1_we;
            w_sel_wmask = m1_wmask;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end
    end

    // Address/data/mask hold their last value when idle; only csb/web return high.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
        end else if (w_accept) begin
            r_csb   <= 1'b0;
            r_web   <= !w_sel_we;
            r_wmask <= w_sel_wmask;
            r_addr  <= w_sel_addr;
            r_din   <= w_sel_wdata;
        end else begin
            r_csb <= 1'b1;
            r_web <= 1'b1;
        end
    end

    // Tag stage 1 travels with the SRAM command, stage 2 with the SRAM data.
    always_ff @(posedge clk_g or posedge rst_g) begin
        if (rst_g) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            r_tag1.rd <= w_accept && !w_sel_we;
            r_tag1.id <= w_grant1 ? c_REQ_ID_LOADER : c_REQ_ID_CORE;
            r_tag2    <= r_tag1;
        end
    end

    assign sram_csb0   = r_csb;
    assign sram_web0   = r_web;
    assign sram_wmask0 = r_wmask;
    assign sram_addr0  = r_addr;
    assign sram_din0   = r_din;

    assign m0_rvalid = r_tag2.rd && (r_tag2.id == c_REQ_ID_CORE);
    assign m1_rvalid = r_tag2.rd && (r_tag2.id == c_REQ_ID_LOADER);
    assign m0_rdata  = sram_dout0;
    assign m1_rdata  = sram_dout0;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Self-checking bench for sram_port_arbiter with an SRAM model,
//            a reference arbitration/memory model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int ADDR_W    = 9;
    localparam int BURST_MAX = 4;

    logic        clk_g = 1'b0;
    logic        rst_g = 1'b1;
    logic        m0_valid = 1'b0, m0_we = 1'b0, m1_valid = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic [8:0]  m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = '0;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
        .clk_g(clk_g), .rst_g(rst_g),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_wmask(m0_wmask),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_wmask(m1_wmask),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk_g = ~clk_g;

    // Synchronous single-port SRAM: one-cycle read latency, byte-masked writes.
    logic [31:0] sram_mem [0:511];
    logic [31:0] sram_wword;
    always @(posedge clk_g) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                sram_wword = sram_mem[sram_addr0];
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) sram_wword[8*b +: 8] = sram_din0[8*b +: 8];
                sram_mem[sram_addr0] <= sram_wword;
            end else begin
                sram_dout0 <= sram_mem[sram_addr0];
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q [$];
    int          grant_log [$];
    logic [31:0] ref_mem [0:511];
    int          n_checks = 0, n_pass = 0;
    int          cyc = 0;
    int          owner = -1, run = 0;
    int          vprob = 50;
    bit          log_en = 1'b0;
    logic [31:0] last_rdata0 = '0;
    int          n_rv1 = 0;
    logic        exp_csb = 1'b1, exp_web = 1'b1;
    logic [3:0]  exp_wmask = '0;
    logic [8:0]  exp_addr = '0;
    logic [31:0] exp_din = '0;

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
    end

    always @(posedge clk_g) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Grant rule: lone requester wins; on contention the owner keeps the port
    // for BURST_MAX consecutive grants, then hands it over.
    function automatic int model_grant(input logic v0, input logic v1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        return 0;
`else
        if (owner < 0) return 0;
        if (run < BURST_MAX) return owner;
        return 1 - owner;
`endif
    endfunction

    // Reference checker: arbitration, SRAM command and expected responses.
    initial begin
        int          g;
        logic        we;
        logic [3:0]  mk;
        logic [8:0]  a;
        logic [31:0] d;
        exp_t        e;
        forever begin
            @(negedge clk_g);
            if (rst_g) begin
                check("rst_csb0", sram_csb0, 1);
                check("rst_web0", sram_web0, 1);
                check("rst_wmask0", sram_wmask0, 0);
                check("rst_addr0", sram_addr0, 0);
                check("rst_din0", sram_din0, 0);
                check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
                exp_q.delete();
                owner = -1; run = 0;
                exp_csb = 1'b1; exp_web = 1'b1;
                exp_wmask = '0; exp_addr = '0; exp_din = '0;
            end else begin
                check("sram_csb0", sram_csb0, exp_csb);
                check("sram_web0", sram_web0, exp_web);
                check("sram_wmask0", sram_wmask0, exp_wmask);
                check("sram_addr0", sram_addr0, exp_addr);
                check("sram_din0", sram_din0, exp_din);
                g = model_grant(m0_valid, m1_valid);
                check("m0_ready", m0_ready, (g == 0));
                check("m1_ready", m1_ready, (g == 1));
                if (log_en) grant_log.push_back(g);
                if (g >= 0) begin
                    we = g ? m1_we : m0_we;
                    mk = g ? m1_wmask : m0_wmask;
                    a  = g ? m1_addr : m0_addr;
                    d  = g ? m1_wdata : m0_wdata;
                    exp_csb = 1'b0; exp_web = !we;
                    exp_wmask = mk; exp_addr = a; exp_din = d;
                    if (we) begin
                        for (int b = 0; b < 4; b++)
                            if (mk[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                    end else begin
                        e.id = g; e.data = ref_mem[a]; e.due = cyc + 2;
                        exp_q.push_back(e);
                    end
                end else begin
                    exp_csb = 1'b1; exp_web = 1'b1;
                end
                if (g < 0) begin
                    owner = -1; run = 0;
                end else if (g == owner) begin
                    if (run < BURST_MAX) run++;
                end else begin
                    owner = g; run = 1;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response is due or seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_g);
            if (!rst_g) begin
                if (m0_rvalid || m1_rvalid) begin
                    if (m0_rvalid) last_rdata0 = m0_rdata;
                    if (m1_rvalid) n_rv1++;
                    check("rvalid_onehot", m0_rvalid & m1_rvalid, 0);
                    if (exp_q.size() == 0) begin
                        check("rvalid_unexpected", {m0_rvalid, m1_rvalid}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_cycle", cyc, e.due);
                        check("rsp_id", {31'd0, m1_rvalid}, e.id);
                        check("rsp_data", m1_rvalid ? m1_rdata : m0_rdata, e.data);
                    end
                end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    check("rvalid_missing", {m0_rvalid, m1_rvalid}, e.id ? 2'b01 : 2'b10);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_g);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic we, input logic [3:0] mk,
                           input logic [8:0] a, input logic [31:0] d);
        if (n == 0) begin
            m0_valid = v; m0_we = we; m0_wmask = mk; m0_addr = a; m0_wdata = d;
        end else begin
            m1_valid = v; m1_we = we; m1_wmask = mk; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic rand_req(input int n);
        logic       v, we;
        logic [8:0] a;
        v  = ($urandom_range(0, 99) < vprob);
        we = $urandom_range(0, 1) == 1;
        a  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
        set_req(n, v, we, 4'($urandom_range(0, 15)), a, $urandom);
    endtask

    initial begin
        bit h0, h1;
        int exp_g;
        repeat (2) @(posedge clk_g);
        #1;
        // First accept in the first cycle out of reset; then read-after-write.
        rst_g = 1'b0;
        set_req(1, 1, 1, 4'hF, 9'h005, 32'hDEADBEEF);
        tick();
        set_req(1, 0, 0, 4'h0, 9'h000, 32'h0);
        set_req(0, 1, 0, 4'h0, 9'h005, 32'h0);
        tick();
        set_req(0, 0, 0, 4'h0, 9'h000, 32'h0);
        repeat (4) tick();
        check("raw_m0_rdata", last_rdata0, 32'hDEADBEEF);
        check("raw_m1_rvalid_count", n_rv1, 0);

        // Partial-mask overwrite at the top address.
        set_req(0, 1, 1, 4'hF, 9'h1FF, 32'h11223344);
        tick();
        set_req(0, 1, 1, 4'h3, 9'h1FF, 32'hAABBCCDD);
        tick();
        set_req(0, 1, 0, 4'h0, 9'h1FF, 32'h0);
        tick();
        set_req(0, 0, 0, 4'h0, 9'h000, 32'h0);
        repeat (4) tick();
        check("mask_m0_rdata", last_rdata0, 32'h1122CCDD);

        // Continuous contention from idle.
        log_en = 1'b1;
        set_req(0, 1, 0, 4'h0, 9'h001, 32'h0);
        set_req(1, 1, 0, 4'h0, 9'h002, 32'h0);
        repeat (12) tick();
        log_en = 1'b0;
        set_req(0, 0, 0, 4'h0, 9'h000, 32'h0);
        set_req(1, 0, 0, 4'h0, 9'h000, 32'h0);
        check("burst_log_len", grant_log.size(), 12);
        for (int i = 0; i < 12 && i < grant_log.size(); i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = (i / BURST_MAX) % 2;
`endif
            check($sformatf("burst_grant_%0d", i), grant_log[i], exp_g);
        end
        repeat (4) tick();

        // Read in flight when reset hits must never return.
        set_req(0, 1, 0, 4'h0, 9'h005, 32'h0);
        tick();
        set_req(0, 0, 0, 4'h0, 9'h000, 32'h0);
        rst_g = 1'b1;
        repeat (2) tick();
        rst_g = 1'b0;
        repeat (5) tick();

        // Randomised traffic: heavy contention, then sparse.
        vprob = 85;
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 400; c++) begin
                @(negedge clk_g);
                h0 = m0_valid && !m0_ready;
                h1 = m1_valid && !m1_ready;
                @(posedge clk_g);
                #1;
                if (!h0) rand_req(0);
                if (!h1) rand_req(1);
            end
            vprob = 35;
        end
        set_req(0, 0, 0, 4'h0, 9'h000, 32'h0);
        set_req(1, 0, 0, 4'h0, 9'h000, 32'h0);
        repeat (5) tick();
        check("drain_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
